regfile_mp: RTL

Parametrised successor to the processor's 2-read/1-write register file. It adds a configurable read-port count, width and depth, and an optional write-to-read bypass. It also replaces initialisation from a memory-image file with a post-reset clear sequencer, so every entry reads as 0 after reset. It sits between the decode stage (register addresses) and the ALU operand muxes.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_clear_seq.sv | 62 ++++++
 rtl/regfile_mp.sv | 103 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: clear-sequencer state
// encoding, default special-register indices and read-port slicing helper.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    localparam int ZERO_REG_DEF = 31;
    localparam int XP_REG_DEF   = 30;

    // Low bit of port k's field inside a packed per-port bus.
    function automatic int rd_slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every register address once, writing zero,
// then hands the storage over to normal operation and raises ready.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RESET_N,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rf_state_t         state;
    rf_state_t         state_nxt;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] ptr_nxt;
    logic              ready_nxt;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= ptr_nxt;
            ready   <= ready_nxt;
        end
    end

    // Exit is an explicit compare against the last address, never the wrap to 0.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = clr_ptr;
        ready_nxt = ready;
        clr_we    = 1'b0;
        case (state)
            CLEAR: begin
                clr_we  = 1'b1;
                ptr_nxt = clr_ptr + 1'b1;
                if (clr_ptr == LAST_ADDR) begin
                    state_nxt = RUN;
                    ready_nxt = 1'b1;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    assign clr_addr = clr_ptr;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD combinational read ports, one write port
// with optional same-cycle bypass, hardwired zero register and post-reset clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter int XP_REG   = XP_REG_DEF,
    parameter int BYPASS   = 1
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     WERF,
    input  logic                     WASEL,
    input  logic                     RA2SEL,
    input  logic [ADDR_W-1:0]        RC,
    input  logic [DATA_W-1:0]        WDATA,
    input  logic [NUM_RD*ADDR_W-1:0] RA_BUS,
    output logic [NUM_RD*DATA_W-1:0] RDATA_BUS,
    output logic                     READY,
    output logic                     WR_DROP
);

    localparam int DEPTH = 1 << ADDR_W;

    if (NUM_RD < 2) begin : g_err_num_rd
        $error("regfile_mp: NUM_RD must be at least 2");
    end
    if (ZERO_REG >= DEPTH || XP_REG >= DEPTH) begin : g_err_reg_range
        $error("regfile_mp: ZERO_REG and XP_REG must be below DEPTH");
    end
    if (ZERO_EN != 0 && XP_REG == ZERO_REG) begin : g_err_xp_zero
        $error("regfile_mp: XP_REG must differ from ZERO_REG when ZERO_EN=1");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] wa;
    logic              wa_zero;
    logic              user_we;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (READY)
    );

    assign wa      = WASEL ? ADDR_W'(XP_REG) : RC;
    assign wa_zero = (ZERO_EN != 0) && (wa == ADDR_W'(ZERO_REG));
    assign user_we = WERF && !clr_we && !wa_zero;

    // Reset alone leaves contents alone; the sequencer does the clearing.
    always_ff @(posedge CLK) begin
        if (RESET_N) begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end else if (user_we) begin
                mem[wa] <= WDATA;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            WR_DROP <= 1'b0;
        end else begin
            WR_DROP <= clr_we && WERF;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        if (k == 1) begin : g_alt_addr
            assign ra = RA2SEL ? RC : RA_BUS[rd_slice_lo(k, ADDR_W) +: ADDR_W];
        end else begin : g_own_addr
            assign ra = RA_BUS[rd_slice_lo(k, ADDR_W) +: ADDR_W];
        end

        always_comb begin
            rd = mem[ra];
            if (clr_we) begin
                rd = '0;
            end else if ((ZERO_EN != 0) && (ra == ADDR_W'(ZERO_REG))) begin
                rd = '0;
            end else if ((BYPASS != 0) && WERF && (ra == wa)) begin
                rd = WDATA;
            end
        end

        assign RDATA_BUS[rd_slice_lo(k, DATA_W) +: DATA_W] = rd;
    end

endmodule
